// File: rtl/timebase_pkg.sv
// Shared constants and elaboration-time helpers for the timebase generator.
package timebase_pkg;

    localparam int unsigned DEF_CLK_HZ      = 50_000_000;
    localparam int unsigned DEF_FRAME_HZ    = 1;
    localparam int unsigned DEF_FRAME_STEPS = 60;
    localparam int unsigned DEF_NUM_EVT     = 2;
    localparam int unsigned DEF_EVT_W       = 8;

    // Ceiling log2, never smaller than 1 so a counter always has at least one bit.
    function automatic int unsigned clog2_min1(input int unsigned v);
        int unsigned r;
        r = 0;
        while ((r < 63) && ((64'(1) << r) < 64'(v))) begin
            r++;
        end
        if (r == 0) begin
            r = 1;
        end
        return r;
    endfunction

    // Clock cycles per step; falls back to 1 when the divisor is degenerate.
    function automatic int unsigned calc_tps(input int unsigned clk_hz,
                                             input int unsigned frame_hz,
                                             input int unsigned frame_steps);
        int unsigned div;
        div = frame_hz * frame_steps;
        if ((div == 0) || (clk_hz < div)) begin
            return 1;
        end
        return clk_hz / div;
    endfunction

    // True when the clock divides evenly into whole step periods.
    function automatic bit tps_exact(input int unsigned clk_hz,
                                     input int unsigned frame_hz,
                                     input int unsigned frame_steps);
        int unsigned div;
        div = frame_hz * frame_steps;
        if ((div == 0) || (clk_hz < div)) begin
            return 1'b0;
        end
        return (clk_hz % div) == 0;
    endfunction

endpackage

// File: rtl/timebase_evt_chan.sv
// One periodic event channel: counts frames and pulses every `period` frames.
module timebase_evt_chan
    import timebase_pkg::*;
#(
    parameter int unsigned EVT_W = DEF_EVT_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             frame_tick,
    input  logic [EVT_W-1:0] period,
    output logic             pulse
);

    logic [EVT_W-1:0] ecnt;
    logic             enabled;
    logic             hit;

    // A shortened period at or below the current count fires on the next frame.
    assign enabled = (period != '0);
    assign hit     = enabled && (ecnt >= (period - EVT_W'(1)));
    assign pulse   = frame_tick & hit;

    // Frame counter; only advances on frame_tick, cleared on pulse or when disabled.
    always_ff @(posedge clk) begin
        if (reset) begin
            ecnt <= '0;
        end else if (frame_tick) begin
            if (!enabled || hit) begin
                ecnt <= '0;
            end else begin
                ecnt <= ecnt + EVT_W'(1);
            end
        end
    end

endmodule

// File: rtl/timebase_gen.sv
// Frame/step timebase with NUM_EVT periodic frame-aligned event pulses.
// Optional feature macro: TIMEBASE_PAUSE_EN adds a pause input that freezes all counters.
module timebase_gen
    import timebase_pkg::*;
#(
    parameter  int unsigned CLK_HZ      = DEF_CLK_HZ,
    parameter  int unsigned FRAME_HZ    = DEF_FRAME_HZ,
    parameter  int unsigned FRAME_STEPS = DEF_FRAME_STEPS,
    parameter  int unsigned NUM_EVT     = DEF_NUM_EVT,
    parameter  int unsigned EVT_W       = DEF_EVT_W,
    localparam int unsigned STEP_W      = clog2_min1(FRAME_STEPS)
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [NUM_EVT*EVT_W-1:0] evt_period,
`ifdef TIMEBASE_PAUSE_EN
    input  logic                     pause,
`endif
    output logic [STEP_W-1:0]        step,
    output logic                     step_tick,
    output logic                     frame_tick,
    output logic [NUM_EVT-1:0]       evt_pulse
);

    localparam int unsigned TPS   = calc_tps(CLK_HZ, FRAME_HZ, FRAME_STEPS);
    localparam int unsigned PRE_W = clog2_min1(TPS);

    // Refuse to build a timebase whose steps would not be whole clock periods.
    if (!tps_exact(CLK_HZ, FRAME_HZ, FRAME_STEPS)) begin : g_bad_params
        $error("timebase_gen: CLK_HZ must be an exact multiple of FRAME_HZ*FRAME_STEPS");
    end

    logic             run;
    logic [PRE_W-1:0] pre;
    logic             pre_last;
    logic             step_last;

`ifdef TIMEBASE_PAUSE_EN
    assign run = ~pause;
`else
    assign run = 1'b1;
`endif

    // Tick decode from registered counters; masked during reset and pause.
    assign pre_last   = (pre == PRE_W'(TPS - 1));
    assign step_last  = (step == STEP_W'(FRAME_STEPS - 1));
    assign step_tick  = pre_last & run & ~reset;
    assign frame_tick = step_tick & step_last;

    // Prescaler and step index, both wrapping.
    always_ff @(posedge clk) begin
        if (reset) begin
            pre  <= '0;
            step <= '0;
        end else if (run) begin
            if (pre_last) begin
                pre <= '0;
                if (step_last) begin
                    step <= '0;
                end else begin
                    step <= step + STEP_W'(1);
                end
            end else begin
                pre <= pre + PRE_W'(1);
            end
        end
    end

    // One independent event channel per period slice.
    for (genvar i = 0; i < int'(NUM_EVT); i++) begin : g_chan
        timebase_evt_chan #(
            .EVT_W (EVT_W)
        ) u_chan (
            .clk        (clk),
            .reset      (reset),
            .frame_tick (frame_tick),
            .period     (evt_period[i*EVT_W +: EVT_W]),
            .pulse      (evt_pulse[i])
        );
    end

endmodule

// File: tb/tb_timebase_gen.sv
// Directed bench for timebase_gen at CLK_HZ=120, FRAME_STEPS=6 (20 clocks per step).
module tb_timebase_gen;

    logic        clk;
    logic        reset;
    logic [15:0] evt_period;
    logic [2:0]  step;
    logic        step_tick;
    logic        frame_tick;
    logic [1:0]  evt_pulse;
`ifdef TIMEBASE_PAUSE_EN
    logic        pause;
`endif

    int n_checks;
    int n_fail;

    typedef struct {
        int         cyc;
        logic       rst;
        logic [7:0] p0;
        logic [7:0] p1;
        logic [2:0] e_step;
        logic       e_st;
        logic       e_ft;
        logic [1:0] e_evt;
    } vec_t;

    vec_t tbl[$];

    timebase_gen #(
        .CLK_HZ      (120),
        .FRAME_HZ    (1),
        .FRAME_STEPS (6),
        .NUM_EVT     (2),
        .EVT_W       (8)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .evt_period (evt_period),
`ifdef TIMEBASE_PAUSE_EN
        .pause      (pause),
`endif
        .step       (step),
        .step_tick  (step_tick),
        .frame_tick (frame_tick),
        .evt_pulse  (evt_pulse)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input int cyc, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s cycle %0d: got 0x%0h expected 0x%0h", name, cyc, act, exp);
        end
    endtask

    function automatic logic [31:0] obs();
        return 32'({step, step_tick, frame_tick, evt_pulse});
    endfunction

    function automatic logic [31:0] pack_exp(input logic [2:0] s, input logic st, input logic ft, input logic [1:0] e);
        return 32'({s, st, ft, e});
    endfunction

    function automatic void add(input int cyc, input logic rst, input logic [7:0] p0, input logic [7:0] p1,
                                input logic [2:0] s, input logic st, input logic ft, input logic [1:0] e);
        vec_t v;
        v.cyc = cyc; v.rst = rst; v.p0 = p0; v.p1 = p1;
        v.e_step = s; v.e_st = st; v.e_ft = ft; v.e_evt = e;
        tbl.push_back(v);
    endfunction

    // Hold reset, check the reset outputs, release so the caller sits in cycle 0.
    task automatic do_reset(input logic [7:0] p1, input logic [7:0] p0);
        reset      = 1'b1;
        evt_period = {p1, p0};
`ifdef TIMEBASE_PAUSE_EN
        pause      = 1'b0;
`endif
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_state", -1, obs(), pack_exp(3'd0, 1'b0, 1'b0, 2'b00));
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int idx;
        int last;
        n_checks = 0;
        n_fail   = 0;

        // Free-running: ch0 period 5, ch1 disabled, every cycle checked.
        do_reset(8'd0, 8'd5);
        for (int c = 0; c < 1300; c++) begin
            logic [2:0] s;
            logic       st;
            logic       ft;
            logic [1:0] e;
            @(negedge clk);
            s  = 3'((c / 20) % 6);
            st = (c % 20) == 19;
            ft = (c % 120) == 119;
            e  = {1'b0, (c == 599) || (c == 1199)};
            check("free_run", c, obs(), pack_exp(s, st, ft, e));
            next_cycle();
        end

        // Period changes, disable/enable and reset landing on a frame/event tick.
        add(  19, 1'b0, 8'd5, 8'd3, 3'd0, 1'b1, 1'b0, 2'b00);
        add( 100, 1'b0, 8'd5, 8'd3, 3'd5, 1'b0, 1'b0, 2'b00);
        add( 119, 1'b0, 8'd5, 8'd3, 3'd5, 1'b1, 1'b1, 2'b00);
        add( 239, 1'b0, 8'd5, 8'd3, 3'd5, 1'b1, 1'b1, 2'b00);
        add( 359, 1'b0, 8'd5, 8'd3, 3'd5, 1'b1, 1'b1, 2'b10);
        add( 479, 1'b0, 8'd5, 8'd3, 3'd5, 1'b1, 1'b1, 2'b00);
        add( 480, 1'b0, 8'd2, 8'd3, 3'd0, 1'b0, 1'b0, 2'b00);
        add( 599, 1'b0, 8'd2, 8'd3, 3'd5, 1'b1, 1'b1, 2'b01);
        add( 719, 1'b0, 8'd2, 8'd3, 3'd5, 1'b1, 1'b1, 2'b10);
        add( 839, 1'b0, 8'd2, 8'd3, 3'd5, 1'b1, 1'b1, 2'b01);
        add( 840, 1'b0, 8'd2, 8'd0, 3'd0, 1'b0, 1'b0, 2'b00);
        add( 959, 1'b0, 8'd2, 8'd0, 3'd5, 1'b1, 1'b1, 2'b00);
        add(1079, 1'b0, 8'd2, 8'd0, 3'd5, 1'b1, 1'b1, 2'b01);
        add(1080, 1'b0, 8'd2, 8'd3, 3'd0, 1'b0, 1'b0, 2'b00);
        add(1199, 1'b0, 8'd2, 8'd3, 3'd5, 1'b1, 1'b1, 2'b00);
        add(1319, 1'b1, 8'd2, 8'd3, 3'd5, 1'b0, 1'b0, 2'b00);
        add(1320, 1'b0, 8'd2, 8'd3, 3'd0, 1'b0, 1'b0, 2'b00);
        add(1339, 1'b0, 8'd2, 8'd3, 3'd0, 1'b1, 1'b0, 2'b00);
        add(1439, 1'b0, 8'd2, 8'd3, 3'd5, 1'b1, 1'b1, 2'b00);
        add(1559, 1'b0, 8'd2, 8'd3, 3'd5, 1'b1, 1'b1, 2'b01);
        add(1679, 1'b0, 8'd2, 8'd3, 3'd5, 1'b1, 1'b1, 2'b10);

        do_reset(8'd3, 8'd5);
        idx  = 0;
        last = tbl[tbl.size()-1].cyc;
        for (int c = 0; c <= last; c++) begin
            logic hit;
            hit = (idx < tbl.size()) && (tbl[idx].cyc == c);
            if (hit) begin
                reset      = tbl[idx].rst;
                evt_period = {tbl[idx].p1, tbl[idx].p0};
            end
            @(negedge clk);
            if (hit) begin
                check("table", c, obs(), pack_exp(tbl[idx].e_step, tbl[idx].e_st, tbl[idx].e_ft, tbl[idx].e_evt));
                idx++;
            end
            next_cycle();
        end
        check("table_all_applied", last, 32'(idx), 32'(tbl.size()));

        // One-cycle reset mid-step: counters restart, next tick 20 cycles after release.
        do_reset(8'd0, 8'd0);
        for (int c = 0; c < 118; c++) begin
            reset = (c == 77);
            @(negedge clk);
            if (c == 77) begin
                check("rst77_during", c, obs(), pack_exp(3'd3, 1'b0, 1'b0, 2'b00));
            end else if (c == 78) begin
                check("rst77_after", c, obs(), pack_exp(3'd0, 1'b0, 1'b0, 2'b00));
            end else if (c > 78 && c < 97) begin
                check("rst77_no_tick", c, 32'(step_tick), 32'(0));
            end else if (c == 97) begin
                check("rst77_first_tick", c, obs(), pack_exp(3'd0, 1'b1, 1'b0, 2'b00));
            end else if (c == 117) begin
                check("rst77_second_tick", c, obs(), pack_exp(3'd1, 1'b1, 1'b0, 2'b00));
            end
            next_cycle();
        end

`ifdef TIMEBASE_PAUSE_EN
        // Pause over cycles 50..79 shifts all later ticks by 30 cycles.
        do_reset(8'd0, 8'd1);
        for (int c = 0; c < 160; c++) begin
            logic st;
            logic ft;
            pause = (c >= 50) && (c <= 79);
            @(negedge clk);
            st = (c == 19) || (c == 39) || (c == 89) || (c == 109) || (c == 129) || (c == 149);
            ft = (c == 149);
            check("pause", c, 32'({step_tick, frame_tick, evt_pulse}), 32'({st, ft, 1'b0, ft}));
            next_cycle();
        end
        pause = 1'b0;
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
